// File: rtl/boot_rom_pkg.sv
// Shared constants and helpers for the boot ROM arbiter.
// Holds the ROM geometry, the default window base and the address-decode helpers.
package boot_rom_pkg;

    localparam int unsigned BOOT_ROM_AW = 10;
    localparam int unsigned BOOT_ROM_DW = 32;
    localparam logic [31:0] BOOT_ROM_BASE_ADDR = 32'h0000_8000;

    // Width of a port index; a single port still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Hit: inside the 4 KiB window and word aligned.
    function automatic logic rom_hit(input logic [31:0] addr, input logic [19:0] base_page);
        return (addr[31:12] == base_page) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo N.
// Produces a one-hot grant and the matching binary index (zero when nothing is requested).
module rr_arbiter
    import boot_rom_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]                req,
    input  logic [idx_width(N)-1:0]     ptr,
    output logic [N-1:0]                gnt,
    output logic [idx_width(N)-1:0]     idx
);

    localparam int unsigned IW = idx_width(N);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // Upper segment [ptr, N-1] has priority over the wrapped segment [0, ptr-1].
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j < int'(ptr))) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Multi-master round-robin front end for a single-ported boot ROM.
// One access per cycle; the response returns exactly one cycle after the grant.
module boot_rom_arbiter
    import boot_rom_pkg::*;
#(
    parameter int unsigned NPORTS    = 2,
    parameter logic [31:0] BASE_ADDR = BOOT_ROM_BASE_ADDR
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [NPORTS-1:0]            req_i,
    input  logic [NPORTS-1:0][31:0]      addr_i,
    output logic [NPORTS-1:0]            gnt_o,
    output logic [NPORTS-1:0]            rvalid_o,
    output logic [BOOT_ROM_DW-1:0]       rdata_o,
    output logic                         err_o,
    output logic                         rom_csn_o,
    output logic [BOOT_ROM_AW-1:0]       rom_a_o,
    input  logic [BOOT_ROM_DW-1:0]       rom_q_i
);

    localparam int unsigned IW = idx_width(NPORTS);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] gnt_idx;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          granted;
    logic          hit;
    logic [31:0]   sel_addr;

    rr_arbiter #(
        .N   (NPORTS)
    ) u_rr_arbiter (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (gnt_o),
        .idx (gnt_idx)
    );

    always_comb begin
        granted  = |req_i;
        sel_addr = addr_i[gnt_idx];
        hit      = rom_hit(sel_addr, BASE_ADDR[31:12]);

        // The ROM is never selected while reset is held, even if a request is present.
        rom_csn_o = ~(RSTN & granted & hit);
        rom_a_o   = granted ? sel_addr[11:2] : '0;

        valid_d = granted;
        err_d   = granted & ~hit;
        owner_d = gnt_idx;

        ptr_d = ptr_q;
        if (granted) begin
            ptr_d = (gnt_idx == IW'(NPORTS - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ptr_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int k = 0; k < NPORTS; k++) begin
            rvalid_o[k] = valid_q && (owner_q == IW'(k));
        end
        err_o   = valid_q & err_q;
        // ROM data is only forwarded for a hit; errors and idle cycles read as zero.
        rdata_o = (valid_q && !err_q) ? rom_q_i : '0;
    end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Self-checking bench for boot_rom_arbiter: directed vector table, reset corner cases
// and a randomized run scored against a transaction-level reference model.
module tb_boot_rom_arbiter;

    localparam int          NP   = 2;
    localparam logic [31:0] BASE = 32'h0000_8000;

    logic                  clk  = 1'b0;
    logic                  rstn = 1'b0;
    logic [NP-1:0]         req  = '0;
    logic [NP-1:0][31:0]   addr = '0;
    logic [NP-1:0]         gnt;
    logic [NP-1:0]         rvalid;
    logic [31:0]           rdata;
    logic                  err;
    logic                  rom_csn;
    logic [9:0]            rom_a;
    logic [31:0]           rom_q = '0;

    always #5 clk = ~clk;

    boot_rom_arbiter #(
        .NPORTS    (NP),
        .BASE_ADDR (BASE)
    ) dut (
        .CLK       (clk),
        .RSTN      (rstn),
        .req_i     (req),
        .addr_i    (addr),
        .gnt_o     (gnt),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .err_o     (err),
        .rom_csn_o (rom_csn),
        .rom_a_o   (rom_a),
        .rom_q_i   (rom_q)
    );

    function automatic logic [31:0] rom_word(input int unsigned i);
        if (i == 0) return 32'h0000_0013;
        if (i == 2) return 32'hff9f_f06f;
        return 32'hc0de_0000 | i;
    endfunction

    // Synchronous ROM: data appears the cycle after select, then holds.
    always @(posedge clk) begin
        if (!rom_csn) rom_q <= rom_word(32'(rom_a));
    end

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  gnt;
        logic        csn;
        logic        chk_a;
        logic [9:0]  a;
        logic [1:0]  rv;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t       rsp_q[$];
    int         m_ptr = 0;
    int         wait_cnt[NP];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] last_gnt;
    vec_t       vecs[14];
    vec_t       nov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict, sample mid-cycle, then advance the model at the edge.
    task automatic step(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1,
                        input bit use_v, input vec_t v);
        int          gi;
        logic [31:0] ga;
        bit          hit;
        logic [1:0]  eg;
        rsp_t        e;
        logic [1:0]  erv;
        logic        eerr;
        logic [31:0] erd;
        req     = r;
        addr[0] = a0;
        addr[1] = a1;
        gi = -1;
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (m_ptr + k) % NP;
            if (gi < 0 && r[p]) gi = p;
        end
        eg  = (gi >= 0) ? 2'(1 << gi) : 2'b00;
        ga  = (gi >= 0) ? addr[gi] : 32'h0;
        hit = (ga >= BASE) && (ga < BASE + 32'd4096) && ((ga % 4) == 0);
        erv = '0; eerr = 1'b0; erd = '0;
        if (rsp_q.size() > 0) begin
            e    = rsp_q.pop_front();
            erv  = 2'(1 << e.port);
            eerr = e.err;
            erd  = e.data;
        end
        #3;
        last_gnt = gnt;
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rom_csn", 32'(rom_csn), 32'(!(gi >= 0 && hit)));
        if (gi < 0) chk("rom_a_idle", 32'(rom_a), 32'h0);
        else if (hit) chk("rom_a", 32'(rom_a), (ga - BASE) / 4);
        chk("rvalid", 32'(rvalid), 32'(erv));
        chk("err", 32'(err), 32'(eerr));
        chk("rdata", rdata, erd);
        if (use_v) begin
            chk("tab_gnt", 32'(gnt), 32'(v.gnt));
            chk("tab_csn", 32'(rom_csn), 32'(v.csn));
            if (v.chk_a) chk("tab_rom_a", 32'(rom_a), 32'(v.a));
            chk("tab_rvalid", 32'(rvalid), 32'(v.rv));
            chk("tab_err", 32'(err), 32'(v.err));
            chk("tab_rdata", rdata, v.rd);
        end
        @(posedge clk);
        if (gi >= 0) begin
            e.port = gi;
            e.err  = !hit;
            e.data = hit ? rom_word((ga - BASE) / 4) : 32'h0;
            rsp_q.push_back(e);
            m_ptr = (gi + 1) % NP;
        end
        for (int p = 0; p < NP; p++) begin
            if (r[p] && !last_gnt[p]) wait_cnt[p]++;
            else wait_cnt[p] = 0;
            if (r[p]) begin
                checks++;
                if (wait_cnt[p] > NP - 1) begin
                    errors++;
                    $display("FAIL starve: port %0d waited %0d cycles, limit %0d", p,
                             wait_cnt[p], NP - 1);
                end
            end
        end
        #1;
    endtask

    // Hold reset for one edge with a live hit request, then release and reset the model.
    task automatic do_reset();
        rstn    = 1'b0;
        req     = 2'b01;
        addr[0] = BASE;
        addr[1] = BASE + 32'd4;
        #3;
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_csn", 32'(rom_csn), 32'h1);
        @(posedge clk);
        #1;
        chk("rst_rvalid_edge", 32'(rvalid), 32'h0);
        rstn = 1'b1;
        req  = '0;
        rsp_q.delete();
        m_ptr = 0;
        for (int p = 0; p < NP; p++) wait_cnt[p] = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r < 5) return BASE + (32'($urandom_range(0, 1023)) << 2);
        if (r == 5) return BASE | (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
        if (r == 6) return BASE + 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
        return $urandom;
    endfunction

    initial begin
        //            req    a0           a1           gnt    csn  chka a      rv     err  rdata
        vecs[0]  = '{2'b01, 32'h8000, 32'h0000, 2'b01, 1'b0, 1'b1, 10'd0, 2'b00, 1'b0, 32'h0};
        vecs[1]  = '{2'b00, 32'h0000, 32'h0000, 2'b00, 1'b1, 1'b1, 10'd0, 2'b01, 1'b0, 32'h0000_0013};
        vecs[2]  = '{2'b10, 32'h0000, 32'h8008, 2'b10, 1'b0, 1'b1, 10'd2, 2'b00, 1'b0, 32'h0};
        vecs[3]  = '{2'b00, 32'h0000, 32'h0000, 2'b00, 1'b1, 1'b1, 10'd0, 2'b10, 1'b0, 32'hff9f_f06f};
        vecs[4]  = '{2'b01, 32'h9000, 32'h0000, 2'b01, 1'b1, 1'b0, 10'd0, 2'b00, 1'b0, 32'h0};
        vecs[5]  = '{2'b01, 32'h8002, 32'h0000, 2'b01, 1'b1, 1'b0, 10'd0, 2'b01, 1'b1, 32'h0};
        vecs[6]  = '{2'b00, 32'h0000, 32'h0000, 2'b00, 1'b1, 1'b1, 10'd0, 2'b01, 1'b1, 32'h0};
        vecs[7]  = '{2'b11, 32'h8004, 32'h800c, 2'b10, 1'b0, 1'b1, 10'd3, 2'b00, 1'b0, 32'h0};
        vecs[8]  = '{2'b11, 32'h8004, 32'h800c, 2'b01, 1'b0, 1'b1, 10'd1, 2'b10, 1'b0, 32'hc0de_0003};
        vecs[9]  = '{2'b11, 32'h8004, 32'h800c, 2'b10, 1'b0, 1'b1, 10'd3, 2'b01, 1'b0, 32'hc0de_0001};
        vecs[10] = '{2'b00, 32'h0000, 32'h0000, 2'b00, 1'b1, 1'b1, 10'd0, 2'b10, 1'b0, 32'hc0de_0003};
        vecs[11] = '{2'b01, 32'h8010, 32'h0000, 2'b01, 1'b0, 1'b1, 10'd4, 2'b00, 1'b0, 32'h0};
        vecs[12] = '{2'b01, 32'h8014, 32'h0000, 2'b01, 1'b0, 1'b1, 10'd5, 2'b01, 1'b0, 32'hc0de_0004};
        vecs[13] = '{2'b00, 32'h0000, 32'h0000, 2'b00, 1'b1, 1'b1, 10'd0, 2'b01, 1'b0, 32'hc0de_0005};
        nov = vecs[0];

        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].req, vecs[i].a0, vecs[i].a1, 1'b1, vecs[i]);
        end

        // Both ports requesting from reset: strict alternation starting at port 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(2'b11, BASE + 32'(i * 8), BASE + 32'(i * 8 + 4), 1'b0, nov);
            chk("rr_order", 32'(last_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        step(2'b00, 32'h0, 32'h0, 1'b0, nov);

        // Grant, then reset before its response: response dropped, pointer back to port 0.
        step(2'b01, BASE + 32'h20, 32'h0, 1'b0, nov);
        do_reset();
        step(2'b11, BASE + 32'h24, BASE + 32'h28, 1'b0, nov);
        chk("post_rst_gnt", 32'(last_gnt), 32'h1);
        step(2'b00, 32'h0, 32'h0, 1'b0, nov);

        for (int i = 0; i < 10000; i++) begin
            step(2'($urandom_range(0, 3)), rand_addr(), rand_addr(), 1'b0, nov);
        end
        step(2'b00, 32'h0, 32'h0, 1'b0, nov);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
